// File: rtl/uart_param_fifo_core.sv
// rtl/uart_param_fifo_core.sv - parametrised UART core: TX/RX FIFOs, baud tick, 16x oversampled RX
// uart_fifo is the shared synchronous FIFO; uart_param_fifo_core is the top.

module uart_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot a full FIFO needs for the push
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end
endmodule

module uart_param_fifo_core #(
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 4,
  parameter int DIV_W   = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [DIV_W-1:0]  BAUD_DIV,
  input  logic              PARITY_EN,
  input  logic              ODD_N_EVEN,
  input  logic              STOP2,
  input  logic              TX_WR,
  input  logic [DATA_W-1:0] TX_DATA,
  output logic              TX_FULL,
  output logic              TX_BUSY,
  input  logic              RX_RD,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_PERR,
  output logic              RX_FERR,
  output logic              RX_EMPTY,
  output logic              OVERFLOW,
  output logic              TX,
  input  logic              RX
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

  // baud tick: one-clock enable every BAUD_DIV+1 clocks
  logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
  logic             tick;
  assign tick = (baud_cnt_q == '0);
  always_comb baud_cnt_d = tick ? BAUD_DIV : baud_cnt_q - DIV_W'(1);

  logic              tx_empty, tx_pop;
  logic [DATA_W-1:0] tx_head;
  uart_fifo #(.W(DATA_W), .AW(FIFO_AW)) u_tx_fifo (
    .clk(CLK), .rst_n(RESET_N), .push(TX_WR), .wdata(TX_DATA),
    .pop(tx_pop), .rdata(tx_head), .full(TX_FULL), .empty(tx_empty)
  );

  state_t            tx_state_q, tx_state_d;
  logic [3:0]        tx_tick_q, tx_tick_d, tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic              tx_par_q, tx_par_d, tx_par_en_q, tx_par_en_d;
  logic              tx_stop2_q, tx_stop2_d, tx_half_q, tx_half_d;
  logic              tx_q, tx_d, tx_load, tx_bit_end;

  assign tx_bit_end = tick && (tx_tick_q == 4'd15);

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_tick_d   = tx_tick_q;
    tx_bit_d    = tx_bit_q;
    tx_sh_d     = tx_sh_q;
    tx_par_d    = tx_par_q;
    tx_par_en_d = tx_par_en_q;
    tx_stop2_d  = tx_stop2_q;
    tx_half_d   = tx_half_q;
    tx_load     = 1'b0;
    if (tick && tx_state_q != S_IDLE) tx_tick_d = tx_tick_q + 4'd1;
    case (tx_state_q)
      S_IDLE:   if (tick && !tx_empty) tx_load = 1'b1;
      S_START:  if (tx_bit_end) begin
                  tx_state_d = S_DATA;
                  tx_bit_d   = 4'd0;
                end
      S_DATA:   if (tx_bit_end) begin
                  tx_sh_d = tx_sh_q >> 1;
                  if (tx_bit_q == LAST_BIT) begin
                    tx_state_d = tx_par_en_q ? S_PARITY : S_STOP;
                    tx_half_d  = 1'b0;
                  end else begin
                    tx_bit_d = tx_bit_q + 4'd1;
                  end
                end
      S_PARITY: if (tx_bit_end) begin
                  tx_state_d = S_STOP;
                  tx_half_d  = 1'b0;
                end
      S_STOP:   if (tx_bit_end) begin
                  if (tx_stop2_q && !tx_half_q) tx_half_d = 1'b1;
                  else if (!tx_empty)           tx_load = 1'b1;
                  else                          tx_state_d = S_IDLE;
                end
      default:  tx_state_d = S_IDLE;
    endcase
    // frame modes are latched with the character so a mid-frame change cannot corrupt it
    if (tx_load) begin
      tx_state_d  = S_START;
      tx_tick_d   = 4'd0;
      tx_sh_d     = tx_head;
      tx_par_d    = (^tx_head) ^ ODD_N_EVEN;
      tx_par_en_d = PARITY_EN;
      tx_stop2_d  = STOP2;
    end
    case (tx_state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = tx_sh_d[0];
      S_PARITY: tx_d = tx_par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx_pop  = tx_load;
  assign TX      = tx_q;
  assign TX_BUSY = (tx_state_q != S_IDLE) || !tx_empty;

  logic              rx_s1_q, rx_s2_q, rx_prev_q;
  state_t            rx_state_q, rx_state_d;
  logic [3:0]        rx_tick_q, rx_tick_d, rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic              rx_v7_q, rx_v7_d, rx_v8_q, rx_v8_d, rx_perr_q, rx_perr_d;
  logic              rx_maj, rx_push, rx_mid, rx_end;
  logic [DATA_W+1:0] rx_wdata, rx_head;
  logic              rx_full, rx_empty, ovf_q, ovf_d;

  assign rx_maj   = (rx_v7_q & rx_v8_q) | (rx_v7_q & rx_s2_q) | (rx_v8_q & rx_s2_q);
  assign rx_mid   = tick && (rx_tick_q == 4'd9);
  assign rx_end   = tick && (rx_tick_q == 4'd15);
  assign rx_wdata = {~rx_maj, rx_perr_q, rx_sh_q};

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_v7_d    = rx_v7_q;
    rx_v8_d    = rx_v8_q;
    rx_perr_d  = rx_perr_q;
    rx_push    = 1'b0;
    if (tick && rx_state_q != S_IDLE) begin
      rx_tick_d = rx_tick_q + 4'd1;
      if (rx_tick_q == 4'd7) rx_v7_d = rx_s2_q;
      if (rx_tick_q == 4'd8) rx_v8_d = rx_s2_q;
    end
    case (rx_state_q)
      S_IDLE:   if (rx_prev_q && !rx_s2_q) begin
                  rx_state_d = S_START;
                  rx_tick_d  = 4'd0;
                  rx_perr_d  = 1'b0;
                end
      S_START:  if (rx_mid && rx_maj) rx_state_d = S_IDLE;
                else if (rx_end) begin
                  rx_state_d = S_DATA;
                  rx_bit_d   = 4'd0;
                end
      S_DATA:   begin
                  if (rx_mid) rx_sh_d = {rx_maj, rx_sh_q[DATA_W-1:1]};
                  if (rx_end) begin
                    if (rx_bit_q == LAST_BIT) rx_state_d = PARITY_EN ? S_PARITY : S_STOP;
                    else                      rx_bit_d   = rx_bit_q + 4'd1;
                  end
                end
      S_PARITY: begin
                  if (rx_mid) rx_perr_d = rx_maj ^ (^rx_sh_q) ^ ODD_N_EVEN;
                  if (rx_end) rx_state_d = S_STOP;
                end
      S_STOP:   if (rx_mid) begin
                  rx_push    = 1'b1;
                  rx_state_d = S_IDLE;
                end
      default:  rx_state_d = S_IDLE;
    endcase
  end

  uart_fifo #(.W(DATA_W + 2), .AW(FIFO_AW)) u_rx_fifo (
    .clk(CLK), .rst_n(RESET_N), .push(rx_push), .wdata(rx_wdata),
    .pop(RX_RD), .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // a drop in the same cycle as a read must stay visible
  always_comb begin
    ovf_d = ovf_q;
    if (RX_RD) ovf_d = 1'b0;
    if (rx_push && rx_full && !RX_RD) ovf_d = 1'b1;
  end

  assign RX_EMPTY = rx_empty;
  assign RX_DATA  = rx_empty ? '0 : rx_head[DATA_W-1:0];
  assign RX_PERR  = !rx_empty && rx_head[DATA_W];
  assign RX_FERR  = !rx_empty && rx_head[DATA_W+1];
  assign OVERFLOW = ovf_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      baud_cnt_q  <= '0;
      tx_state_q  <= S_IDLE;
      tx_tick_q   <= '0;
      tx_bit_q    <= '0;
      tx_sh_q     <= '0;
      tx_par_q    <= 1'b0;
      tx_par_en_q <= 1'b0;
      tx_stop2_q  <= 1'b0;
      tx_half_q   <= 1'b0;
      tx_q        <= 1'b1;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= S_IDLE;
      rx_tick_q   <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      rx_v7_q     <= 1'b1;
      rx_v8_q     <= 1'b1;
      rx_perr_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      baud_cnt_q  <= baud_cnt_d;
      tx_state_q  <= tx_state_d;
      tx_tick_q   <= tx_tick_d;
      tx_bit_q    <= tx_bit_d;
      tx_sh_q     <= tx_sh_d;
      tx_par_q    <= tx_par_d;
      tx_par_en_q <= tx_par_en_d;
      tx_stop2_q  <= tx_stop2_d;
      tx_half_q   <= tx_half_d;
      tx_q        <= tx_d;
      rx_s1_q     <= RX;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      rx_state_q  <= rx_state_d;
      rx_tick_q   <= rx_tick_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      rx_v7_q     <= rx_v7_d;
      rx_v8_q     <= rx_v8_d;
      rx_perr_q   <= rx_perr_d;
      ovf_q       <= ovf_d;
    end
  end
endmodule

// File: tb/tb_uart_param_fifo_core.sv
// tb/tb_uart_param_fifo_core.sv - scoreboard bench for uart_param_fifo_core
// Stimulus queues expected RX entries {ferr, perr, data}; a monitor pops and compares.

module tb_uart_param_fifo_core;
  localparam int DATA_W   = 8;
  localparam int FIFO_AW  = 2;
  localparam int DIV_W    = 16;
  localparam int BIT_CLKS = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DIV_W-1:0]  baud_div;
  logic              parity_en, odd_n_even, stop2;
  logic              tx_wr;
  logic [DATA_W-1:0] tx_data;
  logic              tx_full, tx_busy, tx;
  logic              rx_rd_mon, rd_man, rx_rd;
  logic [DATA_W-1:0] rx_data;
  logic              rx_perr, rx_ferr, rx_empty, overflow;
  logic              loop_en, rx_drv, rx_line;

  logic [9:0] exp_q[$];
  bit         mon_en = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         rx_pops = 0;

  assign rx_line = loop_en ? tx : rx_drv;
  assign rx_rd   = rx_rd_mon | rd_man;

  always #5 clk = ~clk;

  uart_param_fifo_core #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW), .DIV_W(DIV_W)) dut (
    .CLK(clk), .RESET_N(rst_n), .BAUD_DIV(baud_div), .PARITY_EN(parity_en),
    .ODD_N_EVEN(odd_n_even), .STOP2(stop2), .TX_WR(tx_wr), .TX_DATA(tx_data),
    .TX_FULL(tx_full), .TX_BUSY(tx_busy), .RX_RD(rx_rd), .RX_DATA(rx_data),
    .RX_PERR(rx_perr), .RX_FERR(rx_ferr), .RX_EMPTY(rx_empty), .OVERFLOW(overflow),
    .TX(tx), .RX(rx_line)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_le(input string name, input int act, input int limit);
    checks++;
    if (act > limit) begin
      errors++;
      $display("FAIL %s: got %0d, expected at most %0d", name, act, limit);
    end
  endtask

  // monitor: compare the FIFO head with the scoreboard, then pop it
  initial begin
    logic [9:0] e;
    rx_rd_mon = 1'b0;
    forever begin
      @(negedge clk);
      rx_rd_mon = 1'b0;
      if (mon_en && !rx_empty) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got 0x%0h, expected no entry", {rx_ferr, rx_perr, rx_data});
        end else begin
          e = exp_q.pop_front();
          check("rx_head", {22'd0, rx_ferr, rx_perr, rx_data}, {22'd0, e});
        end
        rx_rd_mon = 1'b1;
        rx_pops++;
      end
    end
  end

  initial begin
    #(700_000);
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1);
  end

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [DATA_W-1:0] d);
    tx_data = d;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr   = 1'b0;
  endtask

  task automatic wait_tx(input logic level, input int budget, output int n);
    n = 0;
    while (tx !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_len(input logic level, input int budget, output int len);
    len = 0;
    while (tx === level && len < budget) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input bit par_on, input bit par_bit,
                         input bit stop_bit, input int idle);
    rx_drv = 1'b0;
    clocks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      clocks(BIT_CLKS);
    end
    if (par_on) begin
      rx_drv = par_bit;
      clocks(BIT_CLKS);
    end
    rx_drv = stop_bit;
    clocks(BIT_CLKS);
    rx_drv = 1'b1;
    clocks(idle);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || !rx_empty) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (tx_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("tx_goes_idle", tx_busy, 1'b0);
  endtask

  initial begin
    int n, len, pops0, ne;
    baud_div = 16'd3; parity_en = 0; odd_n_even = 0; stop2 = 0;
    tx_wr = 0; tx_data = '0; rd_man = 0; loop_en = 0; rx_drv = 1'b1;

    @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_tx_full", tx_full, 1'b0);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_rx_empty", rx_empty, 1'b1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_perr_ferr", {rx_perr, rx_ferr}, 2'b00);
    check("rst_overflow", overflow, 1'b0);
    clocks(2);
    rst_n = 1'b1;
    clocks(3);

    // loopback 0x55 then 0xA3, bit width 16*(3+1) clocks
    loop_en = 1; mon_en = 1;
    exp_q.push_back({2'b00, 8'h55});
    exp_q.push_back({2'b00, 8'hA3});
    write_tx(8'h55);
    wait_tx(1'b0, 200, n);
    check_le("tx_start_latency", n + 1, 3 + 3);
    run_len(1'b0, 500, len);
    check("t1_start_width", len, BIT_CLKS);
    run_len(1'b1, 500, len);
    check("t1_bit0_width", len, BIT_CLKS);
    write_tx(8'hA3);
    drain("t1_loopback_drain", 3000);
    wait_idle(2000);

    // odd parity: 0x07 has three ones, so 1 is the wrong bit and 0 the right one
    loop_en = 0; parity_en = 1; odd_n_even = 1;
    exp_q.push_back({2'b01, 8'h07});
    send_rx(8'h07, 1, 1'b1, 1'b1, 32);
    exp_q.push_back({2'b00, 8'h07});
    send_rx(8'h07, 1, 1'b0, 1'b1, 32);
    drain("t2_parity_drain", 500);

    parity_en = 0;
    exp_q.push_back({2'b10, 8'h3C});
    send_rx(8'h3C, 0, 1'b0, 1'b0, 64);
    drain("t3_ferr_drain", 500);

    mon_en = 0;
    rx_drv = 1'b0;
    clocks(2);
    rx_drv = 1'b1;
    ne = 0;
    repeat (1500) begin
      @(negedge clk);
      if (!rx_empty) ne++;
    end
    check("t3_glitch_no_push", ne, 0);

    // overflow: 5 characters into a depth-4 FIFO with no reads
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back({2'b00, 8'h11 + 8'(i)});
      send_rx(8'h11 + 8'(i), 0, 1'b0, 1'b1, 16);
    end
    clocks(64);
    check("t4_overflow_set", overflow, 1'b1);
    check("t4_not_empty", rx_empty, 1'b0);
    mon_en = 1;
    n = 0;
    while (exp_q.size() > 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("t4_overflow_cleared", overflow, 1'b0);
    drain("t4_drain", 200);

    // TX FIFO full while the shifter is busy: 5th write dropped
    loop_en = 1;
    pops0 = rx_pops;
    exp_q.push_back({2'b00, 8'h5A});
    write_tx(8'h5A);
    wait_tx(1'b0, 200, n);
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back({2'b00, 8'(i)});
      write_tx(8'(i));
    end
    check("t5_tx_full", tx_full, 1'b1);
    write_tx(8'h05);
    check("t5_tx_still_full", tx_full, 1'b1);
    drain("t5_tx_drain", 5000);
    wait_idle(2000);
    clocks(800);
    check("t5_frame_count", rx_pops - pops0, 5);

    // RX push and pop in the same cycle on a full FIFO
    loop_en = 0; mon_en = 0;
    for (int i = 0; i < 4; i++) send_rx(8'h21 + 8'(i), 0, 1'b0, 1'b1, 16);
    for (int i = 1; i < 5; i++) exp_q.push_back({2'b00, 8'h21 + 8'(i)});
    fork
      send_rx(8'h25, 0, 1'b0, 1'b1, 16);
      begin
        n = 0;
        while (dut.rx_push !== 1'b1 && n < 1000) begin
          @(negedge clk);
          n++;
        end
        check_le("t5_push_seen", n, 999);
        rd_man = 1'b1;
        @(negedge clk);
        rd_man = 1'b0;
      end
    join
    check("t5_no_overflow", overflow, 1'b0);
    check("t5_still_full", rx_empty, 1'b0);
    mon_en = 1;
    drain("t5_rx_drain", 200);

    // reset mid-DATA
    mon_en = 0;
    send_rx(8'h66, 0, 1'b0, 1'b1, 16);
    write_tx(8'h00);
    write_tx(8'h00);
    wait_tx(1'b0, 200, n);
    clocks(BIT_CLKS + 100);
    check("t6_tx_low_in_data", tx, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_tx_async_high", tx, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    clocks(3);
    check("t6_rx_flushed", rx_empty, 1'b1);
    check("t6_tx_flushed", {tx_busy, tx_full}, 2'b00);
    check("t6_tx_idle", tx, 1'b1);

    // two stop bits, back-to-back frames of 0x00
    loop_en = 1; mon_en = 1; stop2 = 1;
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b00, 8'h00});
    write_tx(8'h00);
    write_tx(8'h00);
    wait_tx(1'b0, 200, n);
    run_len(1'b0, 1000, len);
    check("t6_start_data_low", len, 9 * BIT_CLKS);
    run_len(1'b1, 1000, len);
    check("t6_stop2_width", len, 2 * BIT_CLKS);
    drain("t6_stop2_drain", 3000);
    wait_idle(2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
